// File: rtl/fwd_scoreboard_if.sv
// Decode-to-hazard-unit bundle: issue info and sources in, stall and EX-aligned bypass selects out.
// Latency: fwd_sel is registered (one cycle after decode); stall is combinational in the decode cycle.
// Backpressure: stall is the only backpressure; decode holds its instruction while stall is high.
// Ports: flush, issue_valid/dest/reg_write/mem_read, src_addr, src_used (decode side) ->
//        stall, fwd_sel (hazard-unit side).
interface fwd_scoreboard_if #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                      flush;
    logic                      issue_valid;
    logic [ADDR_W-1:0]         issue_dest;
    logic                      issue_reg_write;
    logic                      issue_mem_read;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]        src_used;
    logic                      stall;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;

    // Decode stage drives the instruction, receives hazard results.
    modport master (
        output flush, issue_valid, issue_dest, issue_reg_write, issue_mem_read,
               src_addr, src_used,
        input  stall, fwd_sel
    );

    // Hazard unit consumes the instruction, produces hazard results.
    modport slave (
        input  flush, issue_valid, issue_dest, issue_reg_write, issue_mem_read,
               src_addr, src_used,
        output stall, fwd_sel
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding/load-use hazard unit: tracks last DEPTH issued destinations, picks per-source bypass.
// Latency: fwd_sel registered, valid the cycle the decode instruction reaches EX; stall combinational.
// Backpressure: stall=1 holds decode for exactly one cycle per load-use and injects a bubble into EX.
// Ports: clk, rst (sync, active-high); bus (slave modport of fwd_scoreboard_if).
module fwd_scoreboard #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    fwd_scoreboard_if.slave   bus
);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] dest;
        logic              wr;
        logic              ld;
    } entry_t;

    // e[0] is the instruction in EX, e[j] is j stages further downstream.
    entry_t e [DEPTH];

    logic [NUM_SRC-1:0][DEPTH-1:0] match;
    logic [NUM_SRC*SEL_W-1:0]      sel_nxt;
    logic [NUM_SRC-1:0]            ld_hit;
    logic                          stall_c;
    logic                          advance;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel_q;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                // $0 is hardwired zero, so it never forwards and never stalls.
                match[i][j] = e[j].v & e[j].wr
                            & (e[j].dest == bus.src_addr[i*ADDR_W +: ADDR_W])
                            & (bus.src_addr[i*ADDR_W +: ADDR_W] != '0)
                            & bus.src_used[i];
            end
        end
    end

    always_comb begin
        sel_nxt = '0;
        ld_hit  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Walk oldest to youngest so the youngest producer overwrites last.
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (match[i][j]) begin
                    sel_nxt[i*SEL_W +: SEL_W] = SEL_W'(j + 1);
                end
            end
            // A load in EX cannot feed a consumer in decode: its data only exists after MEM.
            ld_hit[i] = match[i][0] & e[0].ld;
        end
    end

    assign stall_c = bus.issue_valid & (|ld_hit);
    assign advance = bus.issue_valid & ~stall_c;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            // Only the valid bits matter; stale dest/wr/ld fields are masked by v=0.
            for (int j = 0; j < DEPTH; j++) begin
                e[j].v <= 1'b0;
            end
            fwd_sel_q <= '0;
        end else begin
            for (int j = DEPTH - 1; j > 0; j--) begin
                e[j] <= e[j-1];
            end
            e[0].v    <= advance;
            e[0].dest <= bus.issue_dest;
            e[0].wr   <= bus.issue_reg_write;
            e[0].ld   <= bus.issue_mem_read;
            // A stalled or empty decode slot becomes a bubble in EX with no bypass.
            fwd_sel_q <= advance ? sel_nxt : '0;
        end
    end

    assign bus.stall   = stall_c;
    assign bus.fwd_sel = fwd_sel_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (ADDR_W=5, NUM_SRC=2, DEPTH=3).
// Inputs change 1 time unit after a rising edge; stall is checked after settling,
// fwd_sel is checked 1 time unit after the following edge.
module tb_fwd_scoreboard;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    fwd_scoreboard_if #(.ADDR_W(5), .NUM_SRC(2), .DEPTH(3)) bus ();

    fwd_scoreboard #(.ADDR_W(5), .NUM_SRC(2), .DEPTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [4:0] dest, input logic wr, input logic ld,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
        bus.issue_valid     = v;
        bus.issue_dest      = dest;
        bus.issue_reg_write = wr;
        bus.issue_mem_read  = ld;
        bus.src_addr        = {s1, s0};
        bus.src_used        = used;
        #1;
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        rst       = 1'b1;
        bus.flush = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        chk("reset_stall", bus.stall, 0);
        chk("reset_sel", bus.fwd_sel, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_stall", bus.stall, 0);
            chk("idle_sel", bus.fwd_sel, 0);
        end

        // add $3,$1,$2 then sub $4,$3,$3: both sources bypass from EX/MEM.
        issue(1, 5'd3, 1, 0, 5'd1, 5'd2, 2'b11);
        chk("add_stall", bus.stall, 0);
        tick();
        chk("add_sel", bus.fwd_sel, 0);
        issue(1, 5'd4, 1, 0, 5'd3, 5'd3, 2'b11);
        chk("sub_stall", bus.stall, 0);
        tick();
        chk("sub_sel0", bus.fwd_sel[1:0], 1);
        chk("sub_sel1", bus.fwd_sel[3:2], 1);
        drain();

        // lw $5 then add $6,$5,$0: one bubble, then select 2 from MEM/WB.
        issue(1, 5'd5, 1, 1, 5'd1, 5'd0, 2'b01);
        tick();
        issue(1, 5'd6, 1, 0, 5'd5, 5'd0, 2'b11);
        chk("lu_stall", bus.stall, 1);
        tick();
        chk("lu_bubble_sel", bus.fwd_sel, 0);
        chk("lu_stall_clear", bus.stall, 0);
        tick();
        chk("lu_sel0", bus.fwd_sel[1:0], 2);
        chk("lu_sel1", bus.fwd_sel[3:2], 0);
        drain();

        // Both sources on one load: still a single bubble.
        issue(1, 5'd11, 1, 1, 5'd0, 5'd0, 2'b00);
        tick();
        issue(1, 5'd14, 1, 0, 5'd11, 5'd11, 2'b11);
        chk("lu2_stall", bus.stall, 1);
        tick();
        chk("lu2_stall_clear", bus.stall, 0);
        chk("lu2_bubble_sel", bus.fwd_sel, 0);
        tick();
        chk("lu2_sel", bus.fwd_sel, {2'd2, 2'd2});
        drain();

        // Writers of $7 three and one cycles ahead: youngest wins.
        issue(1, 5'd7, 1, 0, 5'd0, 5'd0, 2'b00);
        tick();
        idle();
        tick();
        issue(1, 5'd7, 1, 0, 5'd0, 5'd0, 2'b00);
        tick();
        issue(1, 5'd15, 1, 0, 5'd7, 5'd0, 2'b01);
        chk("young_stall", bus.stall, 0);
        tick();
        chk("young_sel", bus.fwd_sel[1:0], 1);
        drain();

        // Only the three-cycle-old writer: deepest select.
        issue(1, 5'd7, 1, 0, 5'd0, 5'd0, 2'b00);
        tick();
        idle();
        tick();
        tick();
        issue(1, 5'd15, 1, 0, 5'd7, 5'd0, 2'b01);
        tick();
        chk("deep_sel", bus.fwd_sel[1:0], 3);
        drain();

        // Different sources get different selects in the same cycle.
        issue(1, 5'd12, 1, 0, 5'd0, 5'd0, 2'b00);
        tick();
        issue(1, 5'd13, 1, 0, 5'd0, 5'd0, 2'b00);
        tick();
        issue(1, 5'd16, 1, 0, 5'd13, 5'd12, 2'b11);
        tick();
        chk("mix_sel", bus.fwd_sel, {2'd2, 2'd1});
        drain();

        // Writes to $0 never forward.
        issue(1, 5'd0, 1, 0, 5'd0, 5'd0, 2'b00);
        tick();
        issue(1, 5'd17, 1, 0, 5'd0, 5'd0, 2'b11);
        chk("r0_stall", bus.stall, 0);
        tick();
        chk("r0_sel", bus.fwd_sel, 0);
        drain();

        // Unused sources never forward or stall, even on a load.
        issue(1, 5'd8, 1, 1, 5'd0, 5'd0, 2'b00);
        tick();
        issue(1, 5'd18, 1, 0, 5'd8, 5'd8, 2'b00);
        chk("unused_stall", bus.stall, 0);
        tick();
        chk("unused_sel", bus.fwd_sel, 0);
        drain();

        // Flush squashes the writer and the simultaneous reader.
        issue(1, 5'd9, 1, 0, 5'd0, 5'd0, 2'b00);
        tick();
        bus.flush = 1'b1;
        issue(1, 5'd19, 1, 0, 5'd9, 5'd0, 2'b01);
        tick();
        bus.flush = 1'b0;
        chk("flush_sel", bus.fwd_sel, 0);
        issue(1, 5'd19, 1, 0, 5'd9, 5'd0, 2'b01);
        tick();
        chk("flush_reissue_sel", bus.fwd_sel, 0);
        drain();

        // Same sequence with reset instead of flush.
        issue(1, 5'd9, 1, 0, 5'd0, 5'd0, 2'b00);
        tick();
        rst = 1'b1;
        issue(1, 5'd19, 1, 0, 5'd9, 5'd0, 2'b01);
        tick();
        rst = 1'b0;
        chk("rst_sel", bus.fwd_sel, 0);
        issue(1, 5'd19, 1, 0, 5'd9, 5'd0, 2'b01);
        tick();
        chk("rst_reissue_sel", bus.fwd_sel, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
